// File: rtl/echo_word_packer.sv
// -----------------------------------------------------------------------------
// echo_word_packer
//
// Samples the 1-bit echo comparator after each laser fire, packs a window of
// WORD_W*WORDS_PER_SHOT samples MSB-first into WORD_W-bit words and strobes
// each word out on send_en/tx_data for the transceiver TX lane.
//
// Optional feature macro: ECHO_TEST_PATTERN_EN
//   When defined, adds input test_mode. A shot fired with test_mode=1 emits
//   {8'hA5, 3'b000, word_idx[4:0]} per word instead of sampled echo, with
//   unchanged timing (link bring-up pattern).
//
// Ports:
//   clk          in   system clock, one echo sample per cycle
//   rst          in   asynchronous active-high reset
//   laser_enable in   high = shots allowed; low aborts a shot in progress
//   fire         in   one-cycle laser fire strobe
//   delay_cnt    in   samples skipped after fire before packing starts
//   echo_in      in   synchronised comparator output
//   test_mode    in   (ECHO_TEST_PATTERN_EN only) pattern select, latched at fire
//   send_en      out  one-cycle word strobe, tx_data valid in same cycle
//   tx_data      out  packed word, first sample in MSB; held between strobes
//   shot_done    out  pulse coincident with the last send_en of a shot
//   overrun      out  pulse the cycle after a fire seen outside IDLE
// -----------------------------------------------------------------------------
module echo_word_packer #(
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned WORDS_PER_SHOT = 25,
  parameter int unsigned DELAY_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               laser_enable,
  input  logic               fire,
  input  logic [DELAY_W-1:0] delay_cnt,
  input  logic               echo_in,
`ifdef ECHO_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic               send_en,
  output logic [WORD_W-1:0]  tx_data,
  output logic               shot_done,
  output logic               overrun
);

  localparam int unsigned BIT_CW  = $clog2(WORD_W);
  localparam int unsigned WORD_CW = $clog2(WORDS_PER_SHOT);

  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(WORD_W - 1);
  localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(WORDS_PER_SHOT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PACK
  } state_t;

  // Registered state
  state_t              r_state;
  logic [DELAY_W-1:0]  r_dly;
  logic [BIT_CW-1:0]   r_bit;
  logic [WORD_CW-1:0]  r_word;
  // Only WORD_W-1 bits are stored: the final sample of a word goes straight
  // from echo_in into the output word on the completing edge.
  logic [WORD_W-2:0]   r_shreg;
  logic                r_send;
  logic [WORD_W-1:0]   r_tx;
  logic                r_done;
  logic                r_ovr;
`ifdef ECHO_TEST_PATTERN_EN
  logic                r_test;
`endif

  // Next-state values
  state_t              w_state_nxt;
  logic [DELAY_W-1:0]  w_dly_nxt;
  logic [BIT_CW-1:0]   w_bit_nxt;
  logic [WORD_CW-1:0]  w_word_nxt;
  logic [WORD_W-2:0]   w_shreg_nxt;
  logic                w_send_nxt;
  logic [WORD_W-1:0]   w_tx_nxt;
  logic                w_done_nxt;
  logic                w_ovr_nxt;
`ifdef ECHO_TEST_PATTERN_EN
  logic                w_test_nxt;
  logic [WORD_W-1:0]   w_pattern;
`endif
  logic [WORD_W-1:0]   w_word_full;

  // Current shift contents plus the sample arriving this cycle.
  assign w_word_full = {r_shreg, echo_in};

`ifdef ECHO_TEST_PATTERN_EN
  always_comb begin
    w_pattern                    = '0;
    w_pattern[WORD_W-1 -: 8]     = 8'hA5;
    w_pattern[WORD_CW-1:0]       = r_word;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_shreg <= '0;
      r_send  <= 1'b0;
      r_tx    <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef ECHO_TEST_PATTERN_EN
      r_test  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_bit   <= w_bit_nxt;
      r_word  <= w_word_nxt;
      r_shreg <= w_shreg_nxt;
      r_send  <= w_send_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
`ifdef ECHO_TEST_PATTERN_EN
      r_test  <= w_test_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_bit_nxt   = r_bit;
    w_word_nxt  = r_word;
    w_shreg_nxt = r_shreg;
    w_send_nxt  = 1'b0;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    // Any fire outside IDLE is dropped and flagged one cycle later.
    w_ovr_nxt   = fire && (r_state != S_IDLE);
`ifdef ECHO_TEST_PATTERN_EN
    w_test_nxt  = r_test;
`endif

    case (r_state)
      S_IDLE: begin
        if (fire && laser_enable) begin
          w_dly_nxt   = delay_cnt;
          w_bit_nxt   = '0;
          w_word_nxt  = '0;
          w_shreg_nxt = '0;
`ifdef ECHO_TEST_PATTERN_EN
          w_test_nxt  = test_mode;
`endif
          w_state_nxt = (delay_cnt == '0) ? S_PACK : S_DELAY;
        end
      end

      S_DELAY: begin
        if (!laser_enable) begin
          w_state_nxt = S_IDLE;
          w_dly_nxt   = '0;
          w_bit_nxt   = '0;
          w_word_nxt  = '0;
          w_shreg_nxt = '0;
        end else if (r_dly == DELAY_W'(1)) begin
          // Last skipped sample this cycle; packing starts next cycle.
          w_dly_nxt   = '0;
          w_state_nxt = S_PACK;
        end else begin
          w_dly_nxt   = r_dly - DELAY_W'(1);
        end
      end

      S_PACK: begin
        if (!laser_enable) begin
          // Abort: partial word is discarded, nothing is strobed.
          w_state_nxt = S_IDLE;
          w_bit_nxt   = '0;
          w_word_nxt  = '0;
          w_shreg_nxt = '0;
        end else begin
          w_shreg_nxt = w_word_full[WORD_W-2:0];
          if (r_bit == BIT_LAST) begin
            w_bit_nxt  = '0;
            w_send_nxt = 1'b1;
`ifdef ECHO_TEST_PATTERN_EN
            w_tx_nxt   = r_test ? w_pattern : w_word_full;
`else
            w_tx_nxt   = w_word_full;
`endif
            if (r_word == WORD_LAST) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
              w_word_nxt  = '0;
              w_shreg_nxt = '0;
            end else begin
              w_word_nxt  = r_word + WORD_CW'(1);
            end
          end else begin
            w_bit_nxt = r_bit + BIT_CW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign send_en   = r_send;
  assign tx_data   = r_tx;
  assign shot_done = r_done;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_echo_word_packer.sv
module tb_echo_word_packer;

  localparam int N = 12000;

  logic        clk;
  logic        rst;
  logic        laser_enable;
  logic        fire;
  logic [7:0]  delay_cnt;
  logic        echo_in;
`ifdef ECHO_TEST_PATTERN_EN
  logic        test_mode;
`endif
  logic        send_en;
  logic [15:0] tx_data;
  logic        shot_done;
  logic        overrun;

  echo_word_packer #(
    .WORD_W         (16),
    .WORDS_PER_SHOT (25),
    .DELAY_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .laser_enable (laser_enable),
    .fire         (fire),
    .delay_cnt    (delay_cnt),
    .echo_in      (echo_in),
`ifdef ECHO_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .send_en      (send_en),
    .tx_data      (tx_data),
    .shot_done    (shot_done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: echo per cycle, expected output events per cycle.
  bit          echo_hist [N];
  bit          exp_send  [N];
  bit          exp_done  [N];
  bit          exp_ovr   [N];
  logic [15:0] exp_data  [N];
  logic [15:0] m_tx;
  bit          m_active;
  int          m_end;

  // Observations of the DUT per test window.
  int          cnt;
  int          first_send;
  int          last_done;
  int          last_ovr;
  logic [15:0] first_data;
  logic [15:0] last_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_obs();
    cnt        = 0;
    first_send = -1;
    last_done  = -1;
    last_ovr   = -1;
    first_data = '0;
    last_data  = '0;
  endtask

  task automatic cancel(input int from);
    for (int i = from; i < from + 420 && i < N; i++) begin
      exp_send[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
  endtask

  // A shot fired in cycle t with delay d yields word k in cycle t+d+17+16k,
  // built from samples of cycles t+d+1+16k .. t+d+16+16k, first sample in MSB.
  task automatic schedule(input int t, input int d, input bit tm);
    int c;
    logic [15:0] w;
    m_active = 1'b1;
    m_end    = t + d + 400;
    for (int k = 0; k < 25; k++) begin
      c = t + d + 17 + 16 * k;
      if (tm) begin
        w = 16'hA500 + 16'(k);
      end else begin
        w = '0;
        for (int j = 0; j < 16; j++)
          w[15-j] = echo_hist[t + d + 1 + 16 * k + j];
      end
      exp_send[c] = 1'b1;
      exp_data[c] = w;
      exp_done[c] = (k == 24);
    end
  endtask

  task automatic model_step();
    bit busy;
    bit tm;
    busy = m_active && (cyc <= m_end);
    if (fire && busy) exp_ovr[cyc+1] = 1'b1;
    if (busy && !laser_enable) begin
      cancel(cyc + 1);
      m_active = 1'b0;
    end else if (!busy && fire && laser_enable) begin
`ifdef ECHO_TEST_PATTERN_EN
      tm = test_mode;
`else
      tm = 1'b0;
`endif
      schedule(cyc, int'(delay_cnt), tm);
    end
  endtask

  task automatic check_outputs();
    if (exp_send[cyc]) m_tx = exp_data[cyc];
    chk("send_en",   32'(send_en),   32'(exp_send[cyc]));
    chk("shot_done", 32'(shot_done), 32'(exp_done[cyc]));
    chk("overrun",   32'(overrun),   32'(exp_ovr[cyc]));
    chk("tx_data",   32'(tx_data),   32'(m_tx));
    if (send_en === 1'b1) begin
      cnt++;
      if (first_send < 0) begin
        first_send = cyc;
        first_data = tx_data;
      end
      last_data = tx_data;
    end
    if (shot_done === 1'b1) last_done = cyc;
    if (overrun === 1'b1) last_ovr = cyc;
  endtask

  task automatic cycle();
    echo_in = echo_hist[cyc];
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_cycle();
    echo_in = echo_hist[cyc];
    #2 rst = 1'b1;
    #1;
    chk("rst_send_en",   32'(send_en),   32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_shot_done", 32'(shot_done), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    cancel(cyc);
    exp_ovr[cyc]   = 1'b0;
    exp_ovr[cyc+1] = 1'b0;
    m_tx     = '0;
    m_active = 1'b0;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
  endtask

  task automatic fire_once(input int d);
    delay_cnt = 8'(d);
    fire      = 1'b1;
    cycle();
    fire      = 1'b0;
  endtask

  initial begin
    int t;
    int d;
    int t2;
    int off;

    rst          = 1'b1;
    laser_enable = 1'b1;
    fire         = 1'b0;
    delay_cnt    = '0;
    echo_in      = 1'b0;
`ifdef ECHO_TEST_PATTERN_EN
    test_mode    = 1'b0;
`endif
    m_tx     = '0;
    m_active = 1'b0;
    m_end    = 0;
    for (int i = 0; i < N; i++) echo_hist[i] = 1'($urandom);
    reset_obs();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_send_en",   32'(send_en),   32'd0);
    chk("reset_tx_data",   32'(tx_data),   32'd0);
    chk("reset_shot_done", 32'(shot_done), 32'd0);
    chk("reset_overrun",   32'(overrun),   32'd0);
    rst = 1'b0;
    run(3);

    // 1: delay 0, single high sample right after fire.
    t = cyc;
    for (int i = t + 1; i <= t + 420; i++) echo_hist[i] = 1'b0;
    echo_hist[t+1] = 1'b1;
    reset_obs();
    fire_once(0);
    run(410);
    chk("t1_first_send", first_send, t + 17);
    chk("t1_first_data", 32'(first_data), 32'h8000);
    chk("t1_count",      cnt, 25);
    chk("t1_done_cyc",   last_done, t + 401);

    // 2: delay 8, echo high for exactly the first word window.
    t = cyc;
    for (int i = t + 1; i <= t + 420; i++) echo_hist[i] = (i >= t + 9 && i <= t + 24);
    reset_obs();
    fire_once(8);
    run(415);
    chk("t2_first_send", first_send, t + 25);
    chk("t2_first_data", 32'(first_data), 32'hFFFF);
    chk("t2_last_data",  32'(last_data), 32'h0000);
    chk("t2_count",      cnt, 25);
    chk("t2_done_cyc",   last_done, t + 409);

    // 3: second fire mid-shot.
    d = $urandom_range(0, 20);
    t = cyc;
    reset_obs();
    fire_once(d);
    run(99);
    fire_once($urandom_range(0, 255));
    run(d + 310);
    chk("t3_ovr_cyc",  last_ovr, t + 101);
    chk("t3_count",    cnt, 25);
    chk("t3_done_cyc", last_done, t + d + 401);

    // 4: laser_enable dropped mid-shot, then a clean shot.
    t = cyc;
    reset_obs();
    fire_once(0);
    run(199);
    laser_enable = 1'b0;
    run(30);
    chk("t4_abort_count", cnt, 12);
    chk("t4_abort_done",  last_done, -1);
    fire_once(0);
    run(5);
    chk("t4_disabled_count", cnt, 12);
    laser_enable = 1'b1;
    run(3);
    reset_obs();
    t = cyc;
    fire_once(0);
    run(410);
    chk("t4_clean_count", cnt, 25);
    chk("t4_clean_done",  last_done, t + 401);

    // 5: reset in the middle of a shot.
    t = cyc;
    reset_obs();
    fire_once(0);
    run(49);
    reset_cycle();
    run(420);
    chk("t5_count", cnt, 3);
    chk("t5_done",  last_done, -1);

    // Boundary: max delay, fire on the last capture cycle (overrun), then
    // fire again in the cycle word 24 is presented (accepted).
    t = cyc;
    reset_obs();
    fire_once(255);
    run(255 + 399);
    fire_once(7);
    t2 = cyc;
    fire_once(3);
    run(415);
    chk("bnd_ovr_cyc",   last_ovr, t + 255 + 401);
    chk("bnd_count",     cnt, 50);
    chk("bnd_done_cyc",  last_done, t2 + 3 + 401);

    // Random shots with random extra fires.
    for (int s = 0; s < 4; s++) begin
      d   = $urandom_range(0, 40);
      off = $urandom_range(1, d + 400);
      t   = cyc;
      reset_obs();
      fire_once(d);
      run(off - 1);
      fire_once($urandom_range(0, 255));
      run(d + 420 - off);
      chk("rnd_count",    cnt, 25);
      chk("rnd_done_cyc", last_done, t + d + 401);
    end

`ifdef ECHO_TEST_PATTERN_EN
    // 6: test pattern shot.
    t = cyc;
    reset_obs();
    test_mode = 1'b1;
    fire_once(0);
    test_mode = 1'b0;
    run(410);
    chk("t6_first_send", first_send, t + 17);
    chk("t6_first_data", 32'(first_data), 32'hA500);
    chk("t6_last_data",  32'(last_data), 32'hA518);
    chk("t6_count",      cnt, 25);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
